// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, fixed-latency imem requests and a small {instr, pc} queue toward decode.
// Optional FETCH_ALIGN_CHECK_EN: flag misaligned redirects on err and force redirect target bit 0 low.
module fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic [ADDR_W-1:0] redirect_tgt;
  logic              misalign;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              enq;
  logic              deq;

  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    redirect_tgt = {redirect_pc[ADDR_W-1:1], 1'b0};
    misalign     = redirect_valid & redirect_pc[0];
`else
    redirect_tgt = redirect_pc;
    misalign     = 1'b0;
`endif
  end

  // Occupancy counts the outstanding request so a returning word always has a free slot.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue     = rst && !halt && !redirect_valid && (occupancy < DEPTH_C);
  assign enq       = inflight_q && !drop_q && !redirect_valid;
  assign deq       = (count_q != '0) && instr_ready && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    drop_d        = redirect_valid && issue;
    err_d         = err_q | misalign;
    if (issue) begin
      inflight_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(PC_INC);
      if (enq)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      err_q         <= err_d;
    end
  end

  // Queue storage needs no reset: stale entries are masked off the outputs while empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? instr_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : '0;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table, scoreboard of fetched {instr, pc}, and hand sequences
// for redirect, misaligned redirect (FETCH_ALIGN_CHECK_EN aware), PC wrap and mid-stream reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic rdy;
    logic hlt;
    logic exp_req;
    logic exp_valid;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } ent_t;
  ent_t sb[$];

  logic [15:0] exp_pc;
  logic        pending;
  logic [15:0] pending_addr;
  logic        exp_err;

  fetch_unit #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  // Memory responder: fixed one-cycle latency, data derived from address.
  always @(posedge clk) imem_rdata <= imem_addr ^ 16'hA5A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] tgt_of(input logic [15:0] rp);
`ifdef FETCH_ALIGN_CHECK_EN
    return {rp[15:1], 1'b0};
`else
    return rp;
`endif
  endfunction

  // Called at a falling edge with inputs already applied; checks, then advances one cycle.
  task automatic tick();
    ent_t e;
    #1;
    if (!rst) begin
      sb.delete();
      exp_pc  = 16'h0000;
      pending = 1'b0;
      exp_err = 1'b0;
    end else begin
      chk("instr_valid", instr_valid, sb.size() != 0);
      chk("err", err, exp_err);
      if (instr_valid && instr_ready && !redirect_valid && sb.size() != 0) begin
        e = sb.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.data);
        $display("deq pc=%h instr=%h t=%0t", instr_pc, instr, $time);
      end
      if (pending && !redirect_valid) sb.push_back('{pending_addr ^ 16'hA5A5, pending_addr});
      pending = 1'b0;
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_pc);
        pending      = 1'b1;
        pending_addr = exp_pc;
        exp_pc       = exp_pc + 16'd2;
      end
      if (redirect_valid) begin
        sb.delete();
        pending = 1'b0;
        exp_pc  = tgt_of(redirect_pc);
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_pc[0]) exp_err = 1'b1;
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_rows(input logic r, input logic h, input logic q, input logic v, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{r, h, q, v});
  endtask

  initial begin
    logic [15:0] wrap_exp [4];
    wrap_exp[0] = 16'hFFFC; wrap_exp[1] = 16'hFFFE; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0002;

    // Cycle-by-cycle table from reset release: stream, backpressure, release, halt, resume.
    add_rows(1, 0, 1, 0, 2);
    add_rows(1, 0, 1, 1, 4);
    add_rows(0, 0, 1, 1, 2);
    add_rows(0, 0, 0, 1, 8);
    add_rows(1, 0, 0, 1, 1);
    add_rows(1, 0, 1, 1, 5);
    add_rows(1, 1, 0, 1, 3);
    add_rows(1, 1, 0, 0, 1);
    add_rows(1, 0, 1, 0, 2);
    add_rows(1, 0, 1, 1, 1);

    rst = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    exp_pc = '0; pending = 1'b0; pending_addr = '0; exp_err = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_err", err, 0);
    @(negedge clk);

    rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      instr_ready = vecs[i].rdy;
      halt        = vecs[i].hlt;
      #1;
      chk($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
      chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].exp_valid);
      tick();
    end

    // Redirect with three queued entries and one request in flight.
    instr_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1;
    chk("redir_req_r", imem_req, 0);
    chk("redir_valid_r", instr_valid, 1);
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("redir_valid_r1", instr_valid, 0);
    chk("redir_req_r1", imem_req, 1);
    chk("redir_addr_r1", imem_addr, 16'h0100);
    tick();
    #1;
    chk("redir_valid_r2", instr_valid, 0);
    tick();
    #1;
    chk("redir_valid_r3", instr_valid, 1);
    chk("redir_pc_r3", instr_pc, 16'h0100);
    chk("redir_instr_r3", instr, 16'h0100 ^ 16'hA5A5);
    tick();
    tick();

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 16'h0011;
    #1;
    chk("mis_err_before", err, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_err_after", err, 1);
    chk("mis_addr", imem_addr, 16'h0010);
`else
    chk("mis_err_after", err, 0);
    chk("mis_addr", imem_addr, 16'h0011);
`endif
    for (int i = 0; i < 4; i++) tick();

    // PC wrap through the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("wrap_req%0d", i), imem_req, 1);
      chk($sformatf("wrap_addr%0d", i), imem_addr, wrap_exp[i]);
      tick();
    end
    tick();

    // Asynchronous reset in the middle of a stream.
    rst = 1'b0;
    #1;
    chk("mid_rst_err", err, 0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_req", imem_req, 1);
    for (int i = 0; i < 6; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
